mem_port_arbiter: RTL and testbench

- Shares one single-ported 16-bit memory between the core's instruction-fetch path and its load/store path.
- Sits between the MIPS core and a variable-latency memory that answers each request with an ack.
- Data accesses have fixed priority over fetches.
- A starvation counter forces a fetch grant after a bounded run of consecutive data grants.

---
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between the instruction-fetch path (if_*)
// and the load/store path (d_*) of the core. Data accesses win by default; a
// starvation counter hands the port to a waiting fetch after STARVE_LIMIT
// consecutive data grants.
//
// Every access walks IDLE -> GRANT_x -> RESP -> IDLE, so a zero-wait memory
// gives a 3-cycle request-to-ack time. The RESP cycle holds off re-arbitration
// so a requester can drop or renew its req after seeing ack.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   if_req/if_addr          fetch request (held until if_ack)
//   if_ack/if_rdata         one-cycle completion pulse, fetched word
//   d_req/d_we/d_addr/d_wdata  load/store request (held until d_ack)
//   d_ack/d_rdata           one-cycle completion pulse, load data
//   mem_req/mem_we/mem_addr/mem_wdata  request to memory, held until mem_ack
//   mem_ack/mem_rdata       memory completion and read data
//   busy                    high whenever the FSM is not in IDLE
//
// Parameters
//   ADDR_W, DATA_W          address and data widths
//   STARVE_LIMIT            data grants tolerated while a fetch waits (1..15)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    // load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    // memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              busy
);

    // Counter is 4 bits wide, which is why the limit tops out at 15.
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_D  = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t            state_reg;
    logic [3:0]        starve_cnt_reg;

    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              if_ack_reg;
    logic              d_ack_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              busy_reg;

    // Arbitration decision, only acted upon in IDLE.
    logic              starved_next;
    logic              grant_d_next;
    logic              grant_if_next;
    logic [3:0]        starve_cnt_next;

    always_comb begin
        starved_next    = if_req && (starve_cnt_reg == STARVE_MAX);
        grant_d_next    = d_req && !starved_next;
        grant_if_next   = if_req && !grant_d_next;
        starve_cnt_next = starve_cnt_reg;
        if (grant_d_next) begin
            // Only data grants that actually overtake a waiting fetch count.
            if (!if_req) begin
                starve_cnt_next = 4'd0;
            end else if (starve_cnt_reg < STARVE_MAX) begin
                starve_cnt_next = starve_cnt_reg + 4'd1;
            end
        end else if (grant_if_next) begin
            starve_cnt_next = 4'd0;
        end
    end

    // Single FSM process; every output is a register so the memory and both
    // requesters see glitch-free, edge-aligned handshakes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= 4'd0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            if_ack_reg     <= 1'b0;
            d_ack_reg      <= 1'b0;
            if_rdata_reg   <= '0;
            d_rdata_reg    <= '0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if_ack_reg <= 1'b0;
                    d_ack_reg  <= 1'b0;
                    if (grant_d_next) begin
                        state_reg      <= GRANT_D;
                        starve_cnt_reg <= starve_cnt_next;
                        mem_req_reg    <= 1'b1;
                        mem_we_reg     <= d_we;
                        mem_addr_reg   <= d_addr;
                        mem_wdata_reg  <= d_wdata;
                        busy_reg       <= 1'b1;
                    end else if (grant_if_next) begin
                        state_reg      <= GRANT_IF;
                        starve_cnt_reg <= starve_cnt_next;
                        mem_req_reg    <= 1'b1;
                        mem_we_reg     <= 1'b0;
                        mem_addr_reg   <= if_addr;
                        // No store data on a fetch; avoid leaking stale data.
                        mem_wdata_reg  <= '0;
                        busy_reg       <= 1'b1;
                    end
                end

                GRANT_IF: begin
                    // Completes even if if_req was dropped mid-access.
                    if (mem_ack) begin
                        state_reg    <= RESP;
                        mem_req_reg  <= 1'b0;
                        if_rdata_reg <= mem_rdata;
                        if_ack_reg   <= 1'b1;
                    end
                end

                GRANT_D: begin
                    // Stores capture mem_rdata too; d_rdata is don't-care then.
                    if (mem_ack) begin
                        state_reg   <= RESP;
                        mem_req_reg <= 1'b0;
                        d_rdata_reg <= mem_rdata;
                        d_ack_reg   <= 1'b1;
                    end
                end

                RESP: begin
                    // Ack is visible for this one cycle only; mem_ack ignored.
                    state_reg  <= IDLE;
                    if_ack_reg <= 1'b0;
                    d_ack_reg  <= 1'b0;
                    busy_reg   <= 1'b0;
                end

                default: begin
                    state_reg   <= IDLE;
                    mem_req_reg <= 1'b0;
                    if_ack_reg  <= 1'b0;
                    d_ack_reg   <= 1'b0;
                    busy_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_ack    = if_ack_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_ack     = d_ack_reg;
    assign d_rdata   = d_rdata_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives the fetch and load/store ports, models a variable-latency memory,
// and checks each completion against a queue of expected acks (which port,
// and the read data where it matters).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_port_arbiter #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .STARVE_LIMIT(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    // Untouched locations read back a fixed pattern; address 4 holds 0x1234.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0004) return 16'h1234;
        return a ^ 16'h5A5A;
    endfunction

    logic [15:0] written [logic [15:0]];
    int          mem_wait  = 1;   // mem_req cycles without ack before ack
    int          hi_cnt    = 0;
    logic        model_ack = 1'b0;
    bit          mem_tie   = 1'b0;
    bit          mem_force = 1'b0;

    assign mem_ack = mem_tie | mem_force | model_ack;

    always @(posedge clk) begin
        if (model_ack) begin
            model_ack <= 1'b0;
            hi_cnt    <= 0;
        end else if (mem_req) begin
            if (hi_cnt + 1 == mem_wait) model_ack <= 1'b1;
            hi_cnt <= hi_cnt + 1;
        end else begin
            hi_cnt <= 0;
        end
        if (reset_n && mem_req && mem_ack && mem_we) written[mem_addr] = mem_wdata;
    end

    // Read data presented mid-cycle for whatever address is on the bus.
    always @(negedge clk) begin
        if (written.exists(mem_addr)) mem_rdata <= written[mem_addr];
        else                          mem_rdata <= init_val(mem_addr);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_if;
        bit          chk;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic push_exp(input bit is_if, input bit chk, input logic [15:0] data);
        exp_t e;
        e.is_if = is_if;
        e.chk   = chk;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (if_ack || d_ack) begin
            tests_run++;
            if (if_ack && d_ack) begin
                tests_failed++;
                $display("FAIL ack_dual: if_ack=%0b d_ack=%0b, required only one", if_ack, d_ack);
            end else if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL ack_unexpected: if_ack=%0b d_ack=%0b, required no ack", if_ack, d_ack);
            end else begin
                mon_e = exp_q.pop_front();
                if (if_ack !== mon_e.is_if) begin
                    tests_failed++;
                    $display("FAIL ack_order: got %s ack, required %s ack",
                             if_ack ? "IF" : "D", mon_e.is_if ? "IF" : "D");
                end else if (mon_e.chk && ((if_ack ? if_rdata : d_rdata) !== mon_e.data)) begin
                    tests_failed++;
                    $display("FAIL ack_rdata: %s rdata=%h, required %h",
                             if_ack ? "IF" : "D", if_ack ? if_rdata : d_rdata, mon_e.data);
                end else begin
                    $display("[TB] t=%0t %s ack rdata=%h", $time,
                             if_ack ? "IF" : "D", if_ack ? if_rdata : d_rdata);
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({if_ack, d_ack, mem_req, mem_we, busy} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: {if_ack,d_ack,mem_req,mem_we,busy}=%b, required 00000",
                     {if_ack, d_ack, mem_req, mem_we, busy});
        end
        tests_run++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h d_rdata=%h, required all 0",
                     mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch_alone();
        int  req_cycles = 0;
        int  d_acks     = 0;
        int  cyc        = 0;
        bit  done       = 1'b0;
        mem_wait = 2;
        push_exp(1'b1, 1'b1, 16'h1234);
        if_req  = 1'b1;
        if_addr = 16'h0004;
        while (!done && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (mem_req) req_cycles++;
            if (d_ack)   d_acks++;
            if (if_ack) begin
                done   = 1'b1;
                if_req = 1'b0;
            end
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL fetch_timeout: no if_ack after %0d cycles, required one", cyc);
        end
        tests_run++;
        if (req_cycles != 3) begin
            tests_failed++;
            $display("FAIL fetch_req_cycles: mem_req high %0d cycles, required 3", req_cycles);
        end
        tests_run++;
        if (d_acks != 0) begin
            tests_failed++;
            $display("FAIL fetch_no_dack: %0d d_ack pulses, required 0", d_acks);
        end
        @(negedge clk);
        tests_run++;
        if (if_ack !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_after: if_ack=%b busy=%b, required 0 0", if_ack, busy);
        end
    endtask

    task automatic test_store_alone();
        int cyc  = 0;
        int seen = 0;
        bit done = 1'b0;
        mem_wait = 1;
        push_exp(1'b0, 1'b0, 16'h0000);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0100;
        d_wdata = 16'hBEEF;
        while (!done && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (mem_req) begin
                seen++;
                tests_run++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0100, 16'hBEEF}) begin
                    tests_failed++;
                    $display("FAIL store_bus: we=%b addr=%h wdata=%h, required 1 0100 beef",
                             mem_we, mem_addr, mem_wdata);
                end
            end
            if (d_ack) begin
                done  = 1'b1;
                d_req = 1'b0;
                d_we  = 1'b0;
            end
        end
        tests_run++;
        if (!done || seen == 0) begin
            tests_failed++;
            $display("FAIL store_timeout: done=%0b req_cycles=%0d, required ack after >=1", done, seen);
        end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int cyc     = 0;
        bit seen_d  = 1'b0;
        bit checked = 1'b0;
        bit done    = 1'b0;
        mem_wait = 1;
        // Load reads back the word stored by the previous test.
        push_exp(1'b0, 1'b1, 16'hBEEF);
        push_exp(1'b1, 1'b1, init_val(16'h0008));
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 16'h0100;
        if_req  = 1'b1;
        if_addr = 16'h0008;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (mem_req && seen_d && !checked) begin
                checked = 1'b1;
                tests_run++;
                if ({mem_we, mem_addr} !== {1'b0, 16'h0008}) begin
                    tests_failed++;
                    $display("FAIL simul_fetch_grant: we=%b addr=%h, required 0 0008", mem_we, mem_addr);
                end
            end
            if (d_ack) begin
                seen_d = 1'b1;
                d_req  = 1'b0;
            end
            if (if_ack) begin
                done   = 1'b1;
                if_req = 1'b0;
            end
        end
        tests_run++;
        if (!done || !checked) begin
            tests_failed++;
            $display("FAIL simul_timeout: done=%0b fetch_grant_seen=%0b, required 1 1", done, checked);
        end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        logic [15:0] addrs [5];
        int cyc    = 0;
        int dn     = 0;
        bit ifdone = 1'b0;
        for (int i = 0; i < 5; i++) addrs[i] = 16'h0300 + 16'(i);
        mem_wait = 1;
        for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b1, init_val(addrs[i]));
        push_exp(1'b1, 1'b1, init_val(16'h0200));
        push_exp(1'b0, 1'b1, init_val(addrs[4]));
        if_req  = 1'b1;
        if_addr = 16'h0200;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = addrs[0];
        while ((dn < 5 || !ifdone) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (d_ack) begin
                dn++;
                if (dn == 5) d_req = 1'b0;
                else         d_addr = addrs[dn];
            end
            if (if_ack) begin
                ifdone = 1'b1;
                if_req = 1'b0;
                tests_run++;
                if (dut.starve_cnt_reg !== 4'd0) begin
                    tests_failed++;
                    $display("FAIL starve_cnt_clear: starve_cnt=%0d after IF grant, required 0",
                             dut.starve_cnt_reg);
                end
                tests_run++;
                if (dn != 4) begin
                    tests_failed++;
                    $display("FAIL starve_order: %0d data acks before IF ack, required 4", dn);
                end
            end
        end
        tests_run++;
        if (dn != 5 || !ifdone) begin
            tests_failed++;
            $display("FAIL starve_timeout: data acks=%0d if_done=%0b, required 5 1", dn, ifdone);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_wait();
        mem_tie = 1'b1;
        for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b1, init_val(16'h0020));
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0020;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            tests_run++;
            if (k < 9) begin
                if ({busy, mem_req, d_ack} !== {(k % 3) != 2, (k % 3) == 0, (k % 3) == 1}) begin
                    tests_failed++;
                    $display("FAIL zero_wait_cycle%0d: busy/mem_req/d_ack=%b, required %b", k,
                             {busy, mem_req, d_ack},
                             {(k % 3) != 2, (k % 3) == 0, (k % 3) == 1});
                end
            end else if ({busy, mem_req, d_ack} !== 3'b000) begin
                tests_failed++;
                $display("FAIL zero_wait_idle%0d: busy/mem_req/d_ack=%b, required 000", k,
                         {busy, mem_req, d_ack});
            end
            if (k == 7) d_req = 1'b0;
        end
        mem_tie = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int cyc  = 0;
        int acks = 0;
        mem_wait = 20;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0010;
        while (!mem_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (!mem_req) begin
            tests_failed++;
            $display("FAIL rst_mid_grant: mem_req=%b, required 1 before reset", mem_req);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({mem_req, busy, d_ack, if_ack} !== 4'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: mem_req/busy/d_ack/if_ack=%b, required 0000",
                     {mem_req, busy, d_ack, if_ack});
        end
        tests_run++;
        if ({mem_addr, d_rdata, if_rdata} !== 48'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_data: addr=%h d_rdata=%h if_rdata=%h, required 0",
                     mem_addr, d_rdata, if_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mem_force = 1'b1;
        @(negedge clk);
        mem_force = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (d_ack || if_ack || mem_req) acks++;
        end
        tests_run++;
        if (acks != 0) begin
            tests_failed++;
            $display("FAIL rst_late_ack: %0d cycles with ack/mem_req, required 0", acks);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_alone();
        test_store_alone();
        test_simultaneous();
        test_starvation();
        test_zero_wait();
        test_reset_mid_access();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain: %0d expected acks never arrived, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
